// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register: main + skid entry with valid/ready handshake,
// synchronous flush to a bubble, full throughput with one cycle of stall absorption.
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 97,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Flush,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [CTRL_WIDTH-1:0] In_Ctrl,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [CTRL_WIDTH-1:0] Out_Ctrl,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic [1:0]            Occupancy
);

  // State bits are {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_nxt_state;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;
  logic [DATA_WIDTH-1:0] r_skid_data;

  logic w_main_vld;
  logic w_skid_vld;
  logic w_acc;
  logic w_rel;
  logic w_ld_main;
  logic w_ld_skid;
  logic w_mv_skid;

  assign w_main_vld = r_state[0];
  assign w_skid_vld = r_state[1];

  // In_Ready comes straight from the skid valid flop, so Out_Ready never reaches it.
  assign In_Ready  = ~w_skid_vld;
  assign Out_Valid = w_main_vld;
  assign Out_Ctrl  = w_main_vld ? r_main_ctrl : '0;
  assign Out_Data  = r_main_data;
  assign Occupancy = {1'b0, w_main_vld} + {1'b0, w_skid_vld};

  assign w_acc = In_Valid & In_Ready;
  assign w_rel = Out_Valid & Out_Ready;

  always_comb begin
    w_nxt_state = r_state;
    w_ld_main   = 1'b0;
    w_ld_skid   = 1'b0;
    w_mv_skid   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_ld_main   = 1'b1;
          w_nxt_state = ONE;
        end
      end
      ONE: begin
        if (w_acc && w_rel) begin
          w_ld_main = 1'b1;
        end else if (w_acc) begin
          w_ld_skid   = 1'b1;
          w_nxt_state = FULL;
        end else if (w_rel) begin
          w_nxt_state = EMPTY;
        end
      end
      FULL: begin
        if (w_rel) begin
          w_mv_skid   = 1'b1;
          w_nxt_state = ONE;
        end
      end
      default: w_nxt_state = EMPTY;
    endcase
    // Flush wins over any handshake; data registers keep their contents.
    if (Flush) begin
      w_nxt_state = EMPTY;
      w_ld_main   = 1'b0;
      w_ld_skid   = 1'b0;
      w_mv_skid   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state     <= EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_ld_main) begin
        r_main_ctrl <= In_Ctrl;
        r_main_data <= In_Data;
      end else if (w_mv_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_ld_skid) begin
        r_skid_ctrl <= In_Ctrl;
        r_skid_data <= In_Data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_reg;
  localparam int DW = 97;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst_n, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready;
  logic [CW-1:0] In_Ctrl, Out_Ctrl;
  logic [DW-1:0] In_Data, Out_Data;
  logic [1:0]    Occupancy;

  always #5 Clk = ~Clk;

  pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data),
    .Occupancy(Occupancy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } bundle_t;

  bundle_t       mq[$];
  logic [DW-1:0] m_last = '0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model the edge from the inputs currently applied, then compare at negedge.
  task automatic cycle();
    bit      acc, rel, rst, fl;
    bundle_t b;
    acc = In_Valid && (mq.size() < 2);
    rel = Out_Ready && (mq.size() > 0);
    rst = Rst_n;
    fl  = Flush;
    b.c = In_Ctrl;
    b.d = In_Data;
    @(posedge Clk);
    if (!rst) begin
      mq.delete();
      m_last = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (rel) void'(mq.pop_front());
      if (acc) mq.push_back(b);
    end
    if (mq.size() > 0) m_last = mq[0].d;
    @(negedge Clk);
    check_eq("in_ready",  In_Ready,  mq.size() < 2);
    check_eq("out_valid", Out_Valid, mq.size() > 0);
    check_eq("out_ctrl",  Out_Ctrl,  (mq.size() > 0) ? mq[0].c : '0);
    check_eq("out_data",  Out_Data,  m_last);
    check_eq("occupancy", Occupancy, mq.size());
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    In_Valid = v;
    In_Ctrl  = c;
    In_Data  = d;
  endtask

  initial begin
    logic [127:0] rnd;
    Rst_n = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
    drive(1'b1, 4'h5, 97'h1234);

    // Reset held two cycles with In_Valid high
    cycle(); cycle();
    check_eq("rst_in_ready", In_Ready, 1'b1);
    check_eq("rst_out_valid", Out_Valid, 1'b0);
    check_eq("rst_out_ctrl", Out_Ctrl, 4'h0);
    check_eq("rst_out_data", Out_Data, 97'h0);
    check_eq("rst_occ", Occupancy, 2'd0);

    // Streaming
    Rst_n = 1'b1; Out_Ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'hA, DW'(i));
      cycle();
      check_eq("stream_data", Out_Data, DW'(i));
      check_eq("stream_ctrl", Out_Ctrl, 4'hA);
      check_eq("stream_occ_le1", Occupancy <= 2'd1, 1'b1);
    end
    drive(1'b0, 4'h0, '0);
    cycle();
    check_eq("stream_drain", Out_Valid, 1'b0);

    // Backpressure
    Out_Ready = 1'b0;
    drive(1'b1, 4'h3, 97'h11); cycle();
    drive(1'b1, 4'h3, 97'h22); cycle();
    check_eq("bp_occ", Occupancy, 2'd2);
    check_eq("bp_in_ready", In_Ready, 1'b0);
    check_eq("bp_hold", Out_Data, 97'h11);
    drive(1'b0, 4'h0, '0); cycle();
    check_eq("bp_stall_hold", Out_Data, 97'h11);
    Out_Ready = 1'b1; cycle();
    check_eq("bp_second", Out_Data, 97'h22);
    check_eq("bp_ready_back", In_Ready, 1'b1);
    cycle();
    check_eq("bp_empty", Out_Valid, 1'b0);

    // Flush in FULL
    Out_Ready = 1'b0;
    drive(1'b1, 4'h7, 97'h33); cycle();
    drive(1'b1, 4'h7, 97'h44); cycle();
    check_eq("fl_full_occ", Occupancy, 2'd2);
    drive(1'b0, 4'h0, '0); Flush = 1'b1; cycle();
    Flush = 1'b0;
    check_eq("fl_out_valid", Out_Valid, 1'b0);
    check_eq("fl_out_ctrl", Out_Ctrl, 4'h0);
    check_eq("fl_occ", Occupancy, 2'd0);
    check_eq("fl_in_ready", In_Ready, 1'b1);
    Out_Ready = 1'b1; cycle();
    check_eq("fl_no_44", Out_Valid, 1'b0);

    // Flush with accept in the same cycle
    Out_Ready = 1'b0;
    drive(1'b1, 4'h2, 97'h50); cycle();
    drive(1'b1, 4'h2, 97'h55); Flush = 1'b1; cycle();
    Flush = 1'b0;
    check_eq("fla_empty", Occupancy, 2'd0);
    drive(1'b1, 4'h9, 97'h66); cycle();
    check_eq("fla_66_valid", Out_Valid, 1'b1);
    check_eq("fla_66_data", Out_Data, 97'h66);
    check_eq("fla_66_ctrl", Out_Ctrl, 4'h9);

    // Reset mid-operation from FULL
    drive(1'b1, 4'h1, 97'h77); cycle();
    check_eq("rm_full", Occupancy, 2'd2);
    drive(1'b0, 4'h0, '0); Rst_n = 1'b0; cycle();
    Rst_n = 1'b1;
    check_eq("rm_in_ready", In_Ready, 1'b1);
    check_eq("rm_out_valid", Out_Valid, 1'b0);
    check_eq("rm_out_data", Out_Data, 97'h0);
    check_eq("rm_occ", Occupancy, 2'd0);
    Out_Ready = 1'b1; cycle();
    check_eq("rm_nothing_out", Out_Valid, 1'b0);

    // Randomized traffic; inputs held stable while stalled
    for (int k = 0; k < 3000; k++) begin
      Rst_n     = ($urandom_range(0, 99) != 0);
      Flush     = ($urandom_range(0, 29) == 0);
      Out_Ready = ($urandom_range(0, 2) != 0);
      if (!(In_Valid && mq.size() == 2)) begin
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        drive(($urandom_range(0, 3) != 0), CW'($urandom()), rnd[DW-1:0]);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic inter-stage pipeline register: the next generation of the fixed EX/MEM-style latch.
- Carries a generic data bundle plus a control bundle between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so it runs at full throughput while absorbing one cycle of downstream stall.
- Supports a synchronous flush that turns the stage into a bubble; used between any two stages of the processor pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_WIDTH, 97, width of the datapath bundle (e.g. adder result, ALU result, read data 2, ALU zero).
- CTRL_WIDTH, 4, width of the control bundle (e.g. MemWrite, Branch, RegWrite, MemToReg). Forced to zero when the stage is empty or flushed.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  synchronous active-low reset.
- Flush  in  1  synchronous flush; empties the stage.
- In_Valid  in  1  upstream presents a valid bundle.
- In_Ready  out  1  stage can accept; registered.
- In_Ctrl  in  CTRL_WIDTH  control bundle in.
- In_Data  in  DATA_WIDTH  data bundle in.
- Out_Valid  out  1  stage holds a valid bundle.
- Out_Ready  in  1  downstream accepts.
- Out_Ctrl  out  CTRL_WIDTH  control bundle out; zero whenever Out_Valid=0.
- Out_Data  out  DATA_WIDTH  data bundle out; holds last value when invalid.
- Occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: a main register (drives outputs) and a skid register, each with a valid bit.
- States, encoded by the valid bits:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - FULL: main=1, skid=1.
  - The state main=0, skid=1 is illegal and never reached.
- Definitions:
  - acc = In_Valid & In_Ready.
  - rel = Out_Valid & Out_Ready.
- In_Ready = !skid_valid, driven from a flop with no combinational path from Out_Ready.
- Out_Valid = main_valid.
- Out_Ctrl = main_valid ? main_ctrl : 0.
- Out_Data = main_data, always.
- Transitions on posedge, when Rst_n=1 and Flush=0:
  - EMPTY, acc: load main -> ONE.
  - ONE, acc & rel: load main with the new bundle; stay ONE.
  - ONE, acc & !rel: load skid -> FULL.
  - ONE, !acc & rel: -> EMPTY.
  - FULL, rel: move skid to main, skid invalid -> ONE. No accept is possible in FULL because In_Ready=0.
  - FULL, !rel: hold.
  - Any other combination: hold.
- Latency: 1 cycle from acc to Out_Valid when the stage is empty or draining.
- Throughput: 1 bundle per cycle while Out_Ready=1.
- Ordering is strictly FIFO; no bundle is duplicated or dropped except by Flush or reset.
- Flush=1 at posedge:
  - Both valid bits clear -> EMPTY; In_Ready=1 next cycle.
  - A bundle accepted in the same cycle is discarded.
  - Flush has priority over acc and rel. rel in the flush cycle still counts as consumed downstream.
  - Data registers are not cleared.
- Rst_n=0 at posedge:
  - Both valids and all ctrl registers clear, and data registers clear to 0.
  - In_Ready=1 from the first cycle after reset.
  - Priority: Rst_n > Flush > handshake.
  - Reset mid-operation, including in FULL, discards all contents.
- Occupancy = main_valid + skid_valid.
- Reset values of outputs: In_Ready=1, Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0.
- Upstream contract: In_Ctrl and In_Data must be stable while In_Valid=1 & In_Ready=0. The stage itself never changes Out_Data while Out_Valid=1 & Out_Ready=0.

Test Plan:
- Reset: hold Rst_n=0 for 2 cycles with In_Valid=1 -> In_Ready=1, Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0.
- Streaming: Out_Ready=1; drive In_Data=1..8 with In_Ctrl=4'hA on consecutive cycles -> Out_Data=1..8 one cycle later, back-to-back, Out_Ctrl=4'hA each cycle, Occupancy never exceeds 1.
- Backpressure: send 0x11, 0x22 with Out_Ready=0 -> Occupancy=2 and In_Ready=0 the cycle after the 2nd accept; Out_Data holds 0x11. Raise Out_Ready -> 0x11 then 0x22 appear; In_Ready returns to 1 one cycle after the first release.
- Flush in FULL: state FULL (0x33, 0x44), assert Flush one cycle -> next cycle Out_Valid=0, Out_Ctrl=0, Occupancy=0, In_Ready=1; 0x44 never appears.
- Flush with accept: state ONE, In_Valid=1 with 0x55 and Flush=1 in the same cycle -> 0x55 discarded, stage EMPTY. A following 0x66 emerges normally after 1 cycle.
- Reset mid-operation: FULL with Out_Ready=0, drop Rst_n for 1 cycle -> all outputs at reset values next cycle; prior contents never emitted.
